// File: rtl/pdm_decimator.sv
// PDM decimator: counts ones over a window of 2^DECIM_LOG2 enabled cycles and
// presents one saturated sample per window on a valid/ready output with sticky overrun.
module pdm_decimator #(
    parameter int DECIM_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pdm_in,
    input  logic                  enable,
    output logic [DECIM_LOG2-1:0] sample_out,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic                  overrun
);

    localparam int W = DECIM_LOG2;
    localparam logic [W-1:0] PHASE_LAST = '1;
    localparam logic [W-1:0] PHASE_ONE  = W'(1);

    logic [W-1:0] r_phase;
    logic [W:0]   r_ones;
    logic [W-1:0] r_sample;
    logic         r_valid;
    logic         r_overrun;

    logic         w_complete;
    logic [W:0]   w_total;
    logic [W-1:0] w_sat;

    assign w_complete = enable && (r_phase == PHASE_LAST);
    assign w_total    = r_ones + {{W{1'b0}}, pdm_in};
    // Only an all-ones window reaches 2^W; clamp it to the largest W-bit code.
    assign w_sat      = w_total[W] ? '1 : w_total[W-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order in this block.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_phase   <= '0;
            r_ones    <= '0;
            r_sample  <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (enable) begin
                if (w_complete) begin
                    r_phase <= '0;
                    r_ones  <= '0;
                end else begin
                    r_phase <= r_phase + PHASE_ONE;
                    r_ones  <= w_total;
                end
            end

            if (w_complete) begin
                r_sample <= w_sat;
                r_valid  <= 1'b1;
                if (r_valid && !sample_ready) begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && sample_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign sample_out   = r_sample;
    assign sample_valid = r_valid;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_pdm_decimator.sv
// Self-checking bench for pdm_decimator: table-driven windows, directed corner
// sequences, and randomized traffic against a window-queue reference model.
module tb_pdm_decimator;

    localparam int W   = 5;
    localparam int WIN = 1 << W;
    localparam int MAXV = WIN - 1;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         pdm_in;
    logic         enable;
    logic         sample_ready;
    logic [W-1:0] sample_out;
    logic         sample_valid;
    logic         overrun;

    always #5 clk = ~clk;

    pdm_decimator #(.DECIM_LOG2(W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pdm_in       (pdm_in),
        .enable       (enable),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: bits of the current window kept in a queue; a window
    // closes when it holds WIN bits and its sample is min(popcount, MAXV).
    bit m_bits[$];
    int m_sample;
    bit m_valid;
    bit m_ovr;

    typedef struct {
        int n_ones;
        int exp_sample;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit en, input bit p, input bit rdy);
        bit done;
        int sum;
        done = 1'b0;
        sum  = 0;
        if (!r) begin
            m_bits.delete();
            m_sample = 0;
            m_valid  = 1'b0;
            m_ovr    = 1'b0;
        end else begin
            if (en) begin
                m_bits.push_back(p);
                if (m_bits.size() == WIN) begin
                    done = 1'b1;
                    foreach (m_bits[k]) sum += m_bits[k];
                    m_bits.delete();
                end
            end
            if (done) begin
                if (m_valid && !rdy) m_ovr = 1'b1;
                m_sample = (sum > MAXV) ? MAXV : sum;
                m_valid  = 1'b1;
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic tick(input bit r, input bit en, input bit p, input bit rdy);
        reset_n      = r;
        enable       = en;
        pdm_in       = p;
        sample_ready = rdy;
        @(posedge clk);
        model_step(r, en, p, rdy);
        #1;
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Full enabled window with the first n_ones bits high.
    task automatic run_window(input int n_ones, input bit rdy);
        for (int i = 0; i < WIN; i++) tick(1'b1, 1'b1, i < n_ones, rdy);
    endtask

    initial begin
        int acc;
        int dens;
        bit mbit;

        reset_n = 1'b0; enable = 1'b0; pdm_in = 1'b0; sample_ready = 1'b0;

        // Reset state
        do_reset();
        check("rst_sample", sample_out, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_overrun", overrun, 0);

        // 64 zero bits: valid pulses only after cycles 32 and 64
        for (int i = 0; i < 2 * WIN; i++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b1);
            check("zero_valid", sample_valid, (i == WIN - 1 || i == 2 * WIN - 1));
            if (i == WIN - 1 || i == 2 * WIN - 1) check("zero_sample", sample_out, 0);
        end
        check("zero_overrun", overrun, 0);

        // Table-driven single windows
        vecs[0] = '{0, 0};   vecs[1] = '{1, 1};   vecs[2] = '{10, 10};
        vecs[3] = '{12, 12}; vecs[4] = '{16, 16}; vecs[5] = '{20, 20};
        vecs[6] = '{31, 31}; vecs[7] = '{32, 31};
        foreach (vecs[v]) begin
            do_reset();
            for (int i = 0; i < WIN - 1; i++) tick(1'b1, 1'b1, i < vecs[v].n_ones, 1'b1);
            check("tbl_early_valid", sample_valid, 0);
            tick(1'b1, 1'b1, (WIN - 1) < vecs[v].n_ones, 1'b1);
            check("tbl_valid", sample_valid, 1);
            check("tbl_sample", sample_out, vecs[v].exp_sample);
            tick(1'b1, 1'b0, 1'b0, 1'b1);
            check("tbl_valid_drop", sample_valid, 0);
            check("tbl_overrun", overrun, 0);
        end

        // Constant code 20 from a first-order modulator; first window skipped
        do_reset();
        acc = 0;
        for (int w = 0; w < 4; w++) begin
            for (int i = 0; i < WIN; i++) begin
                acc  = acc + 20;
                mbit = (acc >= WIN);
                acc  = acc % WIN;
                tick(1'b1, 1'b1, mbit, 1'b1);
            end
            if (w > 0) begin
                check("mod20_valid", sample_valid, 1);
                check("mod20_sample", sample_out, 20);
            end
        end

        // Alternating 1/0 gives 16
        do_reset();
        for (int i = 0; i < WIN; i++) tick(1'b1, 1'b1, i[0], 1'b1);
        check("alt_valid", sample_valid, 1);
        check("alt_sample", sample_out, 16);

        // Overrun: ready low across windows of 10 and 20 ones
        do_reset();
        run_window(10, 1'b0);
        check("ovr_w1_valid", sample_valid, 1);
        check("ovr_w1_sample", sample_out, 10);
        for (int i = 0; i < WIN - 1; i++) tick(1'b1, 1'b1, i < 20, 1'b0);
        check("ovr_hold_sample", sample_out, 10);
        check("ovr_hold_overrun", overrun, 0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        check("ovr_w2_sample", sample_out, 20);
        check("ovr_w2_valid", sample_valid, 1);
        check("ovr_w2_overrun", overrun, 1);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        check("ovr_drain_valid", sample_valid, 0);
        check("ovr_sticky", overrun, 1);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        check("ovr_sticky2", overrun, 1);

        // Completion coincides with a transfer: 7 then 9, valid never drops
        do_reset();
        run_window(7, 1'b1);
        check("b2b_a_sample", sample_out, 7);
        for (int i = 0; i < WIN - 1; i++) begin
            tick(1'b1, 1'b1, i < 9, 1'b0);
            check("b2b_hold_valid", sample_valid, 1);
        end
        check("b2b_hold_sample", sample_out, 7);
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        check("b2b_b_valid", sample_valid, 1);
        check("b2b_b_sample", sample_out, 9);
        check("b2b_overrun", overrun, 0);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        check("b2b_drop", sample_valid, 0);

        // Enable gap of 7 cycles mid-window with pdm_in=1 ignored
        do_reset();
        for (int i = 0; i < 16; i++) tick(1'b1, 1'b1, i < 12, 1'b1);
        for (int i = 0; i < 7; i++) begin
            tick(1'b1, 1'b0, 1'b1, 1'b1);
            check("gap_frozen_valid", sample_valid, 0);
        end
        for (int i = 0; i < 15; i++) tick(1'b1, 1'b1, 1'b0, 1'b1);
        check("gap_early_valid", sample_valid, 0);
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        check("gap_valid", sample_valid, 1);
        check("gap_sample", sample_out, 12);

        // Reset mid-window with a pending sample
        do_reset();
        run_window(5, 1'b0);
        check("mrst_pending", sample_valid, 1);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        check("mrst_sample", sample_out, 0);
        check("mrst_valid", sample_valid, 0);
        check("mrst_overrun", overrun, 0);
        for (int i = 0; i < WIN - 1; i++) begin
            tick(1'b1, 1'b1, i < 3, 1'b1);
            check("mrst_no_early", sample_valid, 0);
        end
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        check("mrst_valid_after", sample_valid, 1);
        check("mrst_sample_after", sample_out, 3);

        // Randomized traffic vs reference model
        do_reset();
        dens = 50;
        for (int n = 0; n < 4000; n++) begin
            if (n % 200 == 0) dens = $urandom_range(0, 100);
            tick(($urandom_range(0, 599) != 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 99) < dens),
                 ($urandom_range(0, 2) != 0));
            check("rnd_valid", sample_valid, m_valid);
            check("rnd_sample", sample_out, m_sample);
            check("rnd_overrun", overrun, m_ovr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
